icache_refill: RTL and testbench
================================

// Module: icache_refill
// PURPOSE
//   Miss-refill engine that sits behind the instruction cache. On an ICache miss it
//   reads one aligned block from the byte-wide RAM port, one byte per cycle.
//   It then presents the assembled block, the fill address and a one-cycle write strobe,
//   which feed the cache's write port (we / block / inst_addr).
//   It may be aborted by a pipeline flush.
// PARAMETERS
//   BLOCK_BYTES  16  bytes per cache block; power of 2, >=4; OFF = log2(BLOCK_BYTES)
//   ADDR_WIDTH   32  byte-address width
// PORTS
//   clk_in      in   1               clock; all state changes on rising edge
//   rst_n_in    in   1               reset, asynchronous, active-low
//   rdy_in      in   1               global ready; low = freeze every register
//   flush_in    in   1               abort any refill in progress
//   miss_valid  in   1               cache miss on miss_addr; request a refill
//   miss_addr   in   ADDR_WIDTH      missing instruction address (any alignment)
//   busy        out  1               refill in progress (state != IDLE)
//   mem_a       out  ADDR_WIDTH      RAM byte address (registered)
//   mem_rd      out  1               mem_a carries a valid read this cycle (registered)
//   mem_din     in   8               RAM read data; byte for mem_a of cycle t valid in t+1
//   we          out  1               write strobe to cache, one cycle
//   fill_addr   out  ADDR_WIDTH      block base address for cache index/tag
//   block       out  8*BLOCK_BYTES   assembled block; byte k at [8k+7:8k] (little-endian)
// BEHAVIOUR
//   Reset (rst_n_in=0, async): state=IDLE; mem_a, mem_rd, we, fill_addr, block, counters all 0.
//   rdy_in=0: no register changes (state, counters, mem_a, mem_rd, block held). Outputs stable.
//   Priority each edge: reset > !rdy_in > flush_in > FSM.
//   FSM states IDLE, FETCH, DONE:
//     IDLE: when miss_valid=1:
//       - base <= miss_addr with low OFF bits cleared; fill_addr <= base.
//       - mem_a <= base; mem_rd <= 1; issue cnt <= 1; recv cnt <= 0; go to FETCH.
//     FETCH, each edge:
//       - If cycle carried a read issued last cycle: block byte[recv] <= mem_din; recv++.
//       - If issue cnt < BLOCK_BYTES: mem_a <= base+issue; issue++. Else mem_rd <= 0, mem_a held.
//       - When byte BLOCK_BYTES-1 is stored, go to DONE.
//     DONE: we = 1 (combinational, = state==DONE && !flush_in); next edge -> IDLE.
//   Latency: with miss seen in cycle 0 and rdy_in held high:
//     - mem_a = base+k in cycle k+1; byte k sampled at end of cycle k+2.
//     - we high in cycle BLOCK_BYTES+2 (cycle 18 for the default); total occupancy BLOCK_BYTES+2.
//   Address arithmetic: base+k modulo 2^ADDR_WIDTH; no carry into bits above OFF, since base is aligned.
//   miss_valid is ignored in FETCH and DONE; a new miss is accepted at the earliest in the cycle after DONE.
//   flush_in=1:
//     - Any state -> IDLE at next edge; mem_rd <= 0; we forced 0 that cycle.
//     - Partial block data is discarded, as the next fill rewrites all bytes.
//     - A miss presented in the same IDLE cycle as flush is not accepted.
//   Reset mid-refill: immediate return to IDLE with all outputs 0; no we pulse.
//   block and fill_addr hold their last values after DONE until the next refill starts.
// TESTING
//   1. Reset, miss_addr=0x0000_1234, RAM[0x1230+k]=k+0xA0 ->
//      - mem_a 0x1230..0x123F in cycles 1..16.
//      - we=1 only in cycle 18, fill_addr=0x1230, block[7:0]=0xA0, block[127:120]=0xAF.
//   2. Same as 1, rdy_in low for 3 cycles in cycle 5 ->
//      - mem_a frozen during the stall; we appears in cycle 21.
//      - block identical to test 1.
//   3. flush_in=1 in cycle 9 of a refill ->
//      - busy=0 and mem_rd=0 from cycle 10; no we pulse.
//      - A new miss at 0x2000 then completes with correct data.
//   4. flush_in=1 in the DONE cycle -> we=0 that cycle; busy=0 next cycle.
//   5. miss_valid held high through refill, new miss_addr=0x40 in cycle 19 ->
//      - Second refill starts in cycle 19 (mem_a=0x40 in cycle 20).
//      - Addresses presented during FETCH/DONE are ignored.
//   6. rst_n_in pulled low asynchronously mid-FETCH ->
//      - All outputs 0 before the next edge; state IDLE after release.

Source files
------------

// File: rtl/icache_refill.sv
// Instruction-cache miss refill engine: fetches one aligned block a byte per cycle
// from the RAM port and hands it to the cache write port with a one-cycle strobe.
module icache_refill #(
  parameter int BLOCK_BYTES = 16,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     miss_valid,
  input  logic [ADDR_WIDTH-1:0]    miss_addr,
  output logic                     busy,
  output logic [ADDR_WIDTH-1:0]    mem_a,
  output logic                     mem_rd,
  input  logic [7:0]               mem_din,
  output logic                     we,
  output logic [ADDR_WIDTH-1:0]    fill_addr,
  output logic [8*BLOCK_BYTES-1:0] block
);

  localparam int OFF = $clog2(BLOCK_BYTES);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BLOCK_BYTES - 1);
  localparam logic [OFF:0]          ISSUE_MAX = (OFF + 1)'(BLOCK_BYTES);
  localparam logic [OFF-1:0]        RECV_LAST = OFF'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   base;
  logic [ADDR_WIDTH-1:0]   miss_base;
  logic [OFF:0]            issue_cnt;
  logic [OFF-1:0]          recv_cnt;
  logic                    rd_prev;

  assign miss_base = miss_addr & ~OFF_MASK;
  assign busy      = (state != IDLE);
  assign we        = (state == DONE) && !flush_in;

  // rd_prev remembers that the previous cycle carried a read, so mem_din now holds its byte.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      base      <= '0;
      fill_addr <= '0;
      mem_a     <= '0;
      mem_rd    <= 1'b0;
      block     <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      rd_prev   <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        state   <= IDLE;
        mem_rd  <= 1'b0;
        rd_prev <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (miss_valid) begin
              base      <= miss_base;
              fill_addr <= miss_base;
              mem_a     <= miss_base;
              mem_rd    <= 1'b1;
              issue_cnt <= (OFF + 1)'(1);
              recv_cnt  <= '0;
              rd_prev   <= 1'b0;
              state     <= FETCH;
            end
          end
          FETCH: begin
            rd_prev <= mem_rd;
            if (rd_prev) begin
              block[8*int'(recv_cnt) +: 8] <= mem_din;
              recv_cnt <= recv_cnt + 1'b1;
              if (recv_cnt == RECV_LAST) begin
                state <= DONE;
              end
            end
            if (issue_cnt < ISSUE_MAX) begin
              mem_a     <= base + ADDR_WIDTH'(issue_cnt);
              issue_cnt <= issue_cnt + 1'b1;
            end else begin
              mem_rd <= 1'b0;
            end
          end
          DONE: begin
            rd_prev <= 1'b0;
            state   <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: byte RAM model keyed on address, per-cycle logs
// of the DUT outputs, and hand-computed expected addresses, strobes and blocks.
module tb_icache_refill;

  logic         clk_in;
  logic         rst_n_in;
  logic         rdy_in;
  logic         flush_in;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         busy;
  logic [31:0]  mem_a;
  logic         mem_rd;
  logic [7:0]   mem_din;
  logic         we;
  logic [31:0]  fill_addr;
  logic [127:0] block;

  int checks = 0;
  int errors = 0;

  logic [31:0] aLog    [0:63];
  logic        busyLog [0:63];
  logic        rdLog   [0:63];
  int          weFirst;
  int          weLast;
  int          weCount;

  localparam logic [127:0] BLK_1230 = 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0;
  localparam logic [127:0] BLK_2000 = 128'h7F7E7D7C_7B7A7978_77767574_73727170;
  localparam logic [127:0] BLK_0040 = 128'hBFBEBDBC_BBBAB9B8_B7B6B5B4_B3B2B1B0;

  icache_refill #(.BLOCK_BYTES(16), .ADDR_WIDTH(32)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .busy       (busy),
    .mem_a      (mem_a),
    .mem_rd     (mem_rd),
    .mem_din    (mem_din),
    .we         (we),
    .fill_addr  (fill_addr),
    .block      (block)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ramByte(input logic [31:0] a);
    return a[7:0] + 8'h70;
  endfunction

  // The RAM shares the global ready, so its read pipeline freezes with the engine.
  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= ramByte(mem_a);
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", tag, actual, expected);
    end
  endtask

  // Called at posedge+1; the current cycle is cycle 0 of the sequence.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] addr2, input bit holdMiss,
                               input int stallAt, input int stallLen, input int flushAt, input int maxCycles);
    weFirst = -1;
    weLast  = -1;
    weCount = 0;
    for (int c = 0; c < maxCycles; c++) begin
      miss_valid = holdMiss ? 1'b1 : (c == 0);
      miss_addr  = (c == 0) ? addr : ((c >= 19) ? addr2 : 32'h0000_9990);
      rdy_in     = !(c >= stallAt && c < stallAt + stallLen);
      flush_in   = (c == flushAt);
      @(negedge clk_in);
      aLog[c]    = mem_a;
      busyLog[c] = busy;
      rdLog[c]   = mem_rd;
      if (we) begin
        weCount++;
        if (weFirst < 0) weFirst = c;
        weLast = c;
      end
      @(posedge clk_in);
      #1;
    end
    miss_valid = 1'b0;
    miss_addr  = '0;
    rdy_in     = 1'b1;
    flush_in   = 1'b0;
  endtask

  initial begin
    rst_n_in   = 1'b0;
    rdy_in     = 1'b1;
    flush_in   = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = '0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_a", mem_a, 0);
    checkOutput("rst_mem_rd", mem_rd, 0);
    checkOutput("rst_we", we, 0);
    checkOutput("rst_fill", fill_addr, 0);
    checkOutput("rst_block", block, 0);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    $display("[TB] basic refill at 0x1234");
    applyStimulus(32'h0000_1234, 32'h0, 1'b0, 99, 0, 99, 20);
    for (int k = 0; k < 16; k++) checkOutput($sformatf("t1_mem_a%0d", k), aLog[k+1], 32'h1230 + k);
    checkOutput("t1_rd_c1", rdLog[1], 1);
    checkOutput("t1_rd_c17", rdLog[17], 0);
    checkOutput("t1_busy_c18", busyLog[18], 1);
    checkOutput("t1_busy_c19", busyLog[19], 0);
    checkOutput("t1_we_cnt", weCount, 1);
    checkOutput("t1_we_cyc", weFirst, 18);
    checkOutput("t1_fill", fill_addr, 32'h1230);
    checkOutput("t1_byte0", block[7:0], 8'hA0);
    checkOutput("t1_byte15", block[127:120], 8'hAF);
    checkOutput("t1_block", block, BLK_1230);

    $display("[TB] refill with 3-cycle stall");
    applyStimulus(32'h0000_1234, 32'h0, 1'b0, 5, 3, 99, 24);
    for (int c = 5; c <= 8; c++) checkOutput($sformatf("t2_frozen%0d", c), aLog[c], 32'h1234);
    checkOutput("t2_after_stall", aLog[9], 32'h1235);
    checkOutput("t2_last_addr", aLog[19], 32'h123F);
    checkOutput("t2_we_cnt", weCount, 1);
    checkOutput("t2_we_cyc", weFirst, 21);
    checkOutput("t2_block", block, BLK_1230);

    $display("[TB] flush mid-fetch then refill 0x2000");
    applyStimulus(32'h0000_1234, 32'h0, 1'b0, 99, 0, 9, 20);
    checkOutput("t3_busy_c9", busyLog[9], 1);
    checkOutput("t3_busy_c10", busyLog[10], 0);
    checkOutput("t3_rd_c10", rdLog[10], 0);
    checkOutput("t3_busy_c19", busyLog[19], 0);
    checkOutput("t3_we_cnt", weCount, 0);
    applyStimulus(32'h0000_2000, 32'h0, 1'b0, 99, 0, 99, 20);
    checkOutput("t3b_a1", aLog[1], 32'h2000);
    checkOutput("t3b_we_cyc", weFirst, 18);
    checkOutput("t3b_fill", fill_addr, 32'h2000);
    checkOutput("t3b_block", block, BLK_2000);

    $display("[TB] flush in DONE cycle");
    applyStimulus(32'h0000_1234, 32'h0, 1'b0, 99, 0, 18, 20);
    checkOutput("t4_busy_c18", busyLog[18], 1);
    checkOutput("t4_we_cnt", weCount, 0);
    checkOutput("t4_busy_c19", busyLog[19], 0);

    $display("[TB] miss held high across refill");
    applyStimulus(32'h0000_1234, 32'h0000_0040, 1'b1, 99, 0, 99, 38);
    checkOutput("t5_we_first", weFirst, 18);
    checkOutput("t5_we_last", weLast, 37);
    checkOutput("t5_we_cnt", weCount, 2);
    checkOutput("t5_busy_c19", busyLog[19], 0);
    checkOutput("t5_a19", aLog[19], 32'h123F);
    checkOutput("t5_a20", aLog[20], 32'h0040);
    checkOutput("t5_a35", aLog[35], 32'h004F);
    checkOutput("t5_fill", fill_addr, 32'h0040);
    checkOutput("t5_block", block, BLK_0040);

    $display("[TB] async reset mid-fetch");
    applyStimulus(32'h0000_1234, 32'h0, 1'b0, 99, 0, 99, 6);
    checkOutput("t6_busy_pre", busy, 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_mem_a", mem_a, 0);
    checkOutput("t6_mem_rd", mem_rd, 0);
    checkOutput("t6_we", we, 0);
    checkOutput("t6_fill", fill_addr, 0);
    checkOutput("t6_block", block, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    checkOutput("t6_idle_after", busy, 0);
    applyStimulus(32'h0000_2008, 32'h0, 1'b0, 99, 0, 99, 20);
    checkOutput("t6_re_we_cyc", weFirst, 18);
    checkOutput("t6_re_block", block, BLK_2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
